fsm_input_conditioner: RTL
==========================

# fsm_input_conditioner

Upstream stage of `fsm_exp`. Takes the two raw, asynchronous control inputs and produces the clean, synchronised, debounced `state_inputs[0:1]` vector that `fsm_exp` consumes. Both bits are qualified together, so the FSM never sees a transient or partially-updated input code. The block also provides a one-cycle `changed` strobe and a `stable` flag for the surrounding logic.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles the synchronised input must hold one new value before the output updates. Legal range 1..255.

Ports:
- `clk`, in, 1: single clock; all flops rise on posedge.
- `reset`, in, 1: asynchronous, active-low reset.
- `raw_inputs`, in, [0:1]: unsynchronised raw control inputs.
- `state_inputs`, out, [0:1]: debounced vector, fed directly to `fsm_exp.state_inputs`.
- `changed`, out, 1: registered pulse, high for exactly one cycle when `state_inputs` takes a new value.
- `stable`, out, 1: high when no change is being qualified, i.e. the FSM is in IDLE.

## Operation

- Synchroniser: two flops per bit, `s1 <= raw_inputs`, `s2 <= s1`. Only `s2` is used downstream.
- Qualifier registers:
  - `cand[0:1]`: candidate value.
  - `cnt[7:0]`: hold counter.
  - `state`: IDLE or COUNT.
- IDLE:
  - If `s2 == state_inputs`: stay in IDLE.
  - If `s2 != state_inputs` and DEBOUNCE_CYCLES == 1: `state_inputs <= s2`, `changed <= 1`, stay in IDLE.
  - Otherwise: `cand <= s2`, `cnt <= 1`, go to COUNT.
- COUNT, first matching rule wins:
  - `s2 == state_inputs` (bounced back): `cnt <= 0`, go to IDLE, no output change.
  - `s2 != cand` (moved to a different new code): `cand <= s2`, `cnt <= 1`, stay in COUNT.
  - `cnt == DEBOUNCE_CYCLES-1`: `state_inputs <= cand`, `changed <= 1`, `cnt <= 0`, go to IDLE.
  - Otherwise: `cnt <= cnt + 1`.
- `changed` defaults to 0 every cycle unless one of the rules above sets it.
- `stable = (state == IDLE)`, combinational.
- Both bits update atomically. An intermediate code that is not held for DEBOUNCE_CYCLES consecutive cycles never appears on `state_inputs`.
- `cnt` never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.

## Timing

- Reset (asynchronous, while `reset` = 0):
  - `s1`, `s2`, `cand`, `state_inputs` = 2'b00.
  - `cnt` = 0, `changed` = 0, `state` = IDLE, so `stable` = 1.
  - Reset takes effect immediately, including in the middle of a count; no `changed` pulse is produced.
- Latency: let edge k be the first edge at which `s1` captures the new stable raw value.
  - `s2` holds the new value after edge k+1.
  - COUNT is entered at edge k+2, or the output updates at edge k+2 when DEBOUNCE_CYCLES == 1.
  - `state_inputs` updates at edge k+1+DEBOUNCE_CYCLES. With the default of 4, this is edge k+5.
- `changed` rises on the same edge as the `state_inputs` update and falls on the next edge.
- `stable` goes low the cycle after the comparator first sees `s2 != state_inputs`, and returns high on the update edge or the bounce-back edge.
- Raw changes that are shorter than one clock period may be missed. This is acceptable.

## Test plan

1. **Reset behaviour.** Hold `reset` = 0 with `raw_inputs` = 2'b11 for 3 cycles.
   - During reset: `state_inputs` = 00, `changed` = 0, `stable` = 1.
   - After release, with the first sampling edge as k: `state_inputs` = 11 at edge k+5, with a single `changed` pulse.
2. **Clean step, DEBOUNCE_CYCLES = 4.** `raw_inputs` goes 01→10 and is held.
   - `stable` falls after edge k+2.
   - `state_inputs` is 10 at edge k+5; `changed` is high for exactly that one cycle.
3. **Glitch rejection.** From a settled 00, drive `raw_inputs` = 11 for 2 cycles, then back to 00.
   - `state_inputs` stays 00 and `changed` never asserts.
   - `stable` drops, then returns to 1.
4. **Candidate switch.** From 00, drive `raw_inputs` = 01 for 2 cycles, then 10 and hold. Let j be the first edge that samples 10.
   - `state_inputs` goes directly 00→10 at edge j+5.
   - 01 never appears on `state_inputs`; exactly one `changed` pulse.
5. **Reset mid-count.** Assert `reset` while `cnt` = 2 during a 00→11 qualification.
   - All outputs return to reset values immediately, with no `changed` pulse.
   - After release, the 11 is re-qualified with the full latency.
6. **DEBOUNCE_CYCLES = 1.** Apply a 00→01 step.
   - `state_inputs` = 01 at edge k+2 and `changed` pulses once.
   - Apply a 2-cycle 11 glitch: it propagates to `state_inputs` 11, then back to 01, with two `changed` pulses.

Source files
------------

// File: rtl/fsm_input_conditioner.sv
// Synchronises and debounces the two raw control inputs feeding fsm_exp.
// Both bits are qualified as one code, so a partial update never reaches the output.
module fsm_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:1] raw_inputs,
  output logic [0:1] state_inputs,
  output logic       changed,
  output logic       stable
);

  typedef enum logic {IDLE, COUNT} state_e;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam bit         IMMEDIATE = (DEBOUNCE_CYCLES == 1);

  logic [0:1] s1_q, s2_q;
  logic [0:1] cand_q, out_q;
  logic [7:0] cnt_q;
  logic       changed_q;
  state_e     state_q;

  // Two-flop synchroniser; only s2_q is ever compared downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 2'b00;
      s2_q <= 2'b00;
    end else begin
      s1_q <= raw_inputs;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cand_q    <= 2'b00;
      cnt_q     <= 8'd0;
      out_q     <= 2'b00;
      changed_q <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (s2_q != out_q) begin
            if (IMMEDIATE) begin
              out_q     <= s2_q;
              changed_q <= 1'b1;
            end else begin
              cand_q  <= s2_q;
              cnt_q   <= 8'd1;
              state_q <= COUNT;
            end
          end
        end
        COUNT: begin
          // Rule order matters: a bounce back to the current output wins over a new candidate.
          if (s2_q == out_q) begin
            cnt_q   <= 8'd0;
            state_q <= IDLE;
          end else if (s2_q != cand_q) begin
            cand_q <= s2_q;
            cnt_q  <= 8'd1;
          end else if (cnt_q == CNT_LAST) begin
            out_q     <= cand_q;
            changed_q <= 1'b1;
            cnt_q     <= 8'd0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_inputs = out_q;
  assign changed      = changed_q;
  assign stable       = (state_q == IDLE);

endmodule
